udp_rx_pkt_buffer: RTL and testbench

Packet-level receive buffer directly downstream of the UDP receive stage. Accepts its 32-bit payload word stream (`rec_data_en` / `rec_data` / `rec_end` / `err_flag`) and stores each packet in a circular word RAM. A packet is committed only when it completes cleanly; otherwise it is rolled back. Committed packets are presented to the user logic as a first-word-fall-through (FWFT) packet stream with length and last-word markers.

---
 rtl/udp_rx_pkt_buffer.sv | 144 ++++++++++++++
 tb/tb_udp_rx_pkt_buffer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_pkt_buffer.sv
// Packet receive buffer behind the UDP RX stage: stores payload words in a circular RAM,
// commits or rolls back each packet at rec_end, and replays committed packets as an FWFT stream.
module udp_rx_pkt_buffer #(
   parameter int unsigned ADDR_W     = 9,
   parameter int unsigned DESC_DEPTH = 8
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        rec_data_en,
   input  logic [31:0] rec_data,
   input  logic        rec_end,
   input  logic        err_flag,
   input  logic [15:0] rec_byte_num,
   output logic        pkt_valid,
   output logic [15:0] pkt_len,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        rd_last,
   input  logic        rd_en,
   output logic [15:0] drop_cnt,
   output logic        overflow
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned PW    = ADDR_W + 1;
   localparam int unsigned DW    = $clog2(DESC_DEPTH);
   localparam int unsigned DCW   = DW + 1;

   logic [31:0]    r_mem  [DEPTH];
   logic [15:0]    r_desc [DESC_DEPTH];

   logic [PW-1:0]  r_wr_ptr, r_commit_ptr, r_rd_ptr, r_wcnt;
   logic           r_bad;
   logic [DCW-1:0] r_desc_cnt;
   logic [DW-1:0]  r_desc_wp, r_desc_rp;
   logic           r_pkt_valid, r_rd_valid, r_rd_last, r_overflow;
   logic [15:0]    r_pkt_len, r_rcnt, r_drop_cnt;
   logic [31:0]    r_rd_data;

   logic           w_full, w_wr_acc, w_bad_fin, w_desc_full, w_commit;
   logic [PW-1:0]  w_wcnt_fin, w_wr_ptr_inc;
   logic [16:0]    w_need, w_head_words;
   logic           w_pop, w_desc_pop, w_head_vld, w_fetch, w_new_pkt;
   logic [DW-1:0]  w_desc_rp_nxt;
   logic [DCW-1:0] w_desc_left;
   logic [15:0]    w_head_len, w_rcnt_nxt;

   // Write side and commit decision
   always_comb begin
      w_full       = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH - 1);
      w_wr_acc     = rec_data_en & ~r_bad & ~w_full;
      w_bad_fin    = r_bad | (rec_data_en & w_full);
      w_wcnt_fin   = r_wcnt + PW'(w_wr_acc);
      w_wr_ptr_inc = r_wr_ptr + PW'(w_wr_acc);
      w_need       = (17'(rec_byte_num) + 17'd3) >> 2;
      w_desc_full  = r_desc_cnt == DCW'(DESC_DEPTH);
      w_commit     = rec_end & ~err_flag & ~w_bad_fin & ~w_desc_full &
                     (17'(w_wcnt_fin) == w_need) & (w_need != 17'd0);
   end

   // Read side: descriptor head after any pop, and prefetch into the output register
   always_comb begin
      w_pop         = rd_en & r_rd_valid;
      w_desc_pop    = w_pop & r_rd_last;
      w_desc_rp_nxt = r_desc_rp + DW'(w_desc_pop);
      w_desc_left   = r_desc_cnt - DCW'(w_desc_pop);
      w_head_vld    = w_desc_left != DCW'(0);
      w_head_len    = w_head_vld ? r_desc[w_desc_rp_nxt] : 16'd0;
      w_head_words  = (17'(w_head_len) + 17'd3) >> 2;
      w_fetch       = (r_rd_ptr != r_commit_ptr) & (~r_rd_valid | w_pop);
      w_new_pkt     = ~r_rd_valid | r_rd_last;
      w_rcnt_nxt    = w_new_pkt ? 16'd1 : r_rcnt + 16'd1;
   end

   always_ff @(posedge sys_clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr[ADDR_W-1:0]] <= rec_data;
      if (w_commit) r_desc[r_desc_wp] <= rec_byte_num;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_rd_ptr     <= '0;
         r_wcnt       <= '0;
         r_bad        <= 1'b0;
         r_desc_cnt   <= '0;
         r_desc_wp    <= '0;
         r_desc_rp    <= '0;
         r_pkt_valid  <= 1'b0;
         r_pkt_len    <= '0;
         r_rd_valid   <= 1'b0;
         r_rd_data    <= '0;
         r_rd_last    <= 1'b0;
         r_rcnt       <= '0;
         r_drop_cnt   <= '0;
         r_overflow   <= 1'b0;
      end else begin
         if (rec_end) begin
            r_wcnt <= '0;
            r_bad  <= 1'b0;
            if (w_commit) begin
               r_commit_ptr <= w_wr_ptr_inc;
               r_wr_ptr     <= w_wr_ptr_inc;
            end else begin
               r_wr_ptr   <= r_commit_ptr;
               r_drop_cnt <= r_drop_cnt + 16'd1;
               if (w_bad_fin) r_overflow <= 1'b1;
            end
         end else begin
            r_wr_ptr <= w_wr_ptr_inc;
            r_wcnt   <= w_wcnt_fin;
            r_bad    <= w_bad_fin;
         end

         r_desc_cnt  <= r_desc_cnt + DCW'(w_commit) - DCW'(w_desc_pop);
         r_desc_wp   <= r_desc_wp + DW'(w_commit);
         r_desc_rp   <= w_desc_rp_nxt;
         // Same-cycle pushes surface one cycle later, in step with commit_ptr
         r_pkt_valid <= w_head_vld;
         r_pkt_len   <= w_head_len;

         if (w_fetch) begin
            r_rd_ptr   <= r_rd_ptr + PW'(1);
            r_rd_valid <= 1'b1;
            r_rd_data  <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            r_rcnt     <= w_rcnt_nxt;
            r_rd_last  <= 17'(w_rcnt_nxt) == w_head_words;
         end else if (w_pop) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
         end
      end
   end

   assign pkt_valid = r_pkt_valid;
   assign pkt_len   = r_pkt_len;
   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;
   assign rd_last   = r_rd_last;
   assign drop_cnt  = r_drop_cnt;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_udp_rx_pkt_buffer.sv
// Directed bench for udp_rx_pkt_buffer (small RAM so overflow is reachable).
module tb_udp_rx_pkt_buffer;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        rec_data_en = 1'b0;
   logic [31:0] rec_data = '0;
   logic        rec_end = 1'b0;
   logic        err_flag = 1'b0;
   logic [15:0] rec_byte_num = '0;
   logic        pkt_valid;
   logic [15:0] pkt_len;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        rd_last;
   logic        rd_en = 1'b0;
   logic [15:0] drop_cnt;
   logic        overflow;

   int tests_run = 0;
   int tests_failed = 0;
   logic [31:0] tx [64];

   udp_rx_pkt_buffer #(.ADDR_W(4), .DESC_DEPTH(8)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .rec_data_en(rec_data_en), .rec_data(rec_data), .rec_end(rec_end),
      .err_flag(err_flag), .rec_byte_num(rec_byte_num),
      .pkt_valid(pkt_valid), .pkt_len(pkt_len),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_en(rd_en),
      .drop_cnt(drop_cnt), .overflow(overflow)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic idle_inputs();
      rec_data_en = 1'b0; rec_data = '0; rec_end = 1'b0; err_flag = 1'b0; rec_byte_num = '0;
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst = 1'b1; rd_en = 1'b0; idle_inputs();
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   // Sends tx[0..n-1]; rec_end rides on the last word (alone if n==0). Returns one cycle after rec_end.
   task automatic send_pkt(input int n, input logic [15:0] len, input logic err);
      if (n == 0) begin
         @(negedge sys_clk);
         rec_end = 1'b1; err_flag = err; rec_byte_num = len;
      end
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk);
         rec_data_en = 1'b1; rec_data = tx[i];
         rec_end = (i == n - 1); err_flag = err; rec_byte_num = len;
      end
      @(negedge sys_clk);
      idle_inputs();
   endtask

   task automatic read_word(output logic [31:0] d, output logic l, output logic v,
                            output logic [15:0] len);
      d = rd_data; l = rd_last; v = rd_valid; len = pkt_len;
      rd_en = 1'b1;
      @(negedge sys_clk);
      rd_en = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rd_valid === 1'b1) begin ok = 1'b1; break; end
         @(negedge sys_clk);
      end
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++;
      if ({pkt_valid, rd_valid, rd_last, overflow} !== 4'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b want 0000", {pkt_valid, rd_valid, rd_last, overflow});
      end
      tests_run++;
      if ({rd_data, pkt_len, drop_cnt} !== 64'd0) begin
         tests_failed++;
         $display("FAIL reset_values: data=%h len=%0d drop=%0d want 0", rd_data, pkt_len, drop_cnt);
      end
   endtask

   task automatic test_good_packet();
      logic [31:0] d; logic l, v; logic [15:0] len;
      do_reset();
      tx[0] = 32'h01020304; tx[1] = 32'h05060708; tx[2] = 32'h090A0B0C;
      tx[3] = 32'h0D0E0F10; tx[4] = 32'h11120000;
      send_pkt(5, 16'd18, 1'b0);
      tests_run++;
      if (pkt_valid !== 1'b0) begin
         tests_failed++; $display("FAIL good_early_valid: got %b want 0", pkt_valid);
      end
      @(negedge sys_clk);
      tests_run++;
      if ({pkt_valid, rd_valid, pkt_len} !== {2'b11, 16'd18}) begin
         tests_failed++;
         $display("FAIL good_latency: pv=%b rv=%b len=%0d want 1 1 18", pkt_valid, rd_valid, pkt_len);
      end
      for (int i = 0; i < 5; i++) begin
         read_word(d, l, v, len);
         tests_run++;
         if ({v, d, l, len} !== {1'b1, tx[i], (i == 4), 16'd18}) begin
            tests_failed++;
            $display("FAIL good_word%0d: v=%b d=%h last=%b len=%0d want 1 %h %b 18",
                     i, v, d, l, len, tx[i], (i == 4));
         end
      end
      tests_run++;
      if ({pkt_valid, rd_valid, drop_cnt} !== 18'd0) begin
         tests_failed++;
         $display("FAIL good_after: pv=%b rv=%b drop=%0d want 0 0 0", pkt_valid, rd_valid, drop_cnt);
      end
   endtask

   task automatic test_error_rollback();
      logic [31:0] d; logic l, v; logic [15:0] len; bit ok;
      do_reset();
      for (int i = 0; i < 8; i++) tx[i] = 32'hE0000000 + i;
      send_pkt(8, 16'd32, 1'b1);
      tests_run++;
      if (drop_cnt !== 16'd1) begin
         tests_failed++; $display("FAIL err_drop_cnt: got %0d want 1", drop_cnt);
      end
      repeat (3) @(negedge sys_clk);
      tests_run++;
      if ({pkt_valid, rd_valid} !== 2'b00) begin
         tests_failed++; $display("FAIL err_no_pkt: pv=%b rv=%b want 0 0", pkt_valid, rd_valid);
      end
      for (int i = 0; i < 4; i++) tx[i] = 32'hA0000000 + i;
      send_pkt(4, 16'd16, 1'b0);
      wait_valid(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL err_next_timeout: rd_valid=0 want 1"); end
      for (int i = 0; i < 4; i++) begin
         read_word(d, l, v, len);
         tests_run++;
         if ({v, d, l, len} !== {1'b1, tx[i], (i == 3), 16'd16}) begin
            tests_failed++;
            $display("FAIL err_next_word%0d: v=%b d=%h last=%b len=%0d want 1 %h %b 16",
                     i, v, d, l, len, tx[i], (i == 3));
         end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] d; logic l, v; logic [15:0] len; bit ok;
      do_reset();
      for (int i = 0; i < 20; i++) tx[i] = 32'hB0000000 + i;
      send_pkt(20, 16'd80, 1'b0);
      tests_run++;
      if ({overflow, drop_cnt} !== {1'b1, 16'd1}) begin
         tests_failed++; $display("FAIL ovf_drop: ovf=%b drop=%0d want 1 1", overflow, drop_cnt);
      end
      for (int i = 0; i < 15; i++) tx[i] = 32'hC0000000 + i;
      send_pkt(15, 16'd60, 1'b0);
      wait_valid(ok);
      tests_run++;
      if (!ok || pkt_len !== 16'd60) begin
         tests_failed++; $display("FAIL ovf_full_pkt: rv=%b len=%0d want 1 60", rd_valid, pkt_len);
      end
      for (int i = 0; i < 15; i++) begin
         read_word(d, l, v, len);
         tests_run++;
         if ({v, d, l} !== {1'b1, tx[i], (i == 14)}) begin
            tests_failed++;
            $display("FAIL ovf_word%0d: v=%b d=%h last=%b want 1 %h %b", i, v, d, l, tx[i], (i == 14));
         end
      end
      tests_run++;
      if ({overflow, drop_cnt} !== {1'b1, 16'd1}) begin
         tests_failed++; $display("FAIL ovf_sticky: ovf=%b drop=%0d want 1 1", overflow, drop_cnt);
      end
   endtask

   task automatic test_desc_full();
      logic [31:0] d; logic l, v; logic [15:0] len; bit ok;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         tx[0] = 32'hD0000000 + k;
         send_pkt(1, 16'd4, 1'b0);
      end
      tests_run++;
      if ({drop_cnt, overflow} !== {16'd1, 1'b0}) begin
         tests_failed++; $display("FAIL desc_drop: drop=%0d ovf=%b want 1 0", drop_cnt, overflow);
      end
      for (int k = 0; k < 8; k++) begin
         wait_valid(ok);
         read_word(d, l, v, len);
         tests_run++;
         if ({ok, d, l, len} !== {1'b1, 32'hD0000000 + k, 1'b1, 16'd4}) begin
            tests_failed++;
            $display("FAIL desc_pkt%0d: ok=%b d=%h last=%b len=%0d want 1 %h 1 4",
                     k, ok, d, l, len, 32'hD0000000 + k);
         end
      end
      tests_run++;
      if ({pkt_valid, rd_valid} !== 2'b00) begin
         tests_failed++; $display("FAIL desc_empty: pv=%b rv=%b want 0 0", pkt_valid, rd_valid);
      end
   endtask

   task automatic test_len_mismatch();
      do_reset();
      tx[0] = 32'h11111111; tx[1] = 32'h22222222;
      send_pkt(2, 16'd10, 1'b0);
      send_pkt(0, 16'd0, 1'b0);
      repeat (3) @(negedge sys_clk);
      tests_run++;
      if ({drop_cnt, pkt_valid, overflow} !== {16'd2, 2'b00}) begin
         tests_failed++;
         $display("FAIL len_mismatch: drop=%0d pv=%b ovf=%b want 2 0 0", drop_cnt, pkt_valid, overflow);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got_d [$];
      logic        got_l [$];
      logic [31:0] d; logic l, v; logic [15:0] len; bit ok;
      do_reset();
      fork
         begin
            for (int p = 0; p < 3; p++)
               for (int i = 0; i < 6; i++) begin
                  @(negedge sys_clk);
                  rec_data_en = 1'b1; rec_data = 32'h50000000 | (p << 8) | i;
                  rec_end = (i == 5); rec_byte_num = 16'd24;
               end
            @(negedge sys_clk);
            idle_inputs();
         end
         begin
            rd_en = 1'b1;
            repeat (50) begin
               @(negedge sys_clk);
               if (rd_valid === 1'b1) begin got_d.push_back(rd_data); got_l.push_back(rd_last); end
            end
         end
      join
      rd_en = 1'b0;
      tests_run++;
      if (got_d.size() != 18) begin
         tests_failed++; $display("FAIL stream_count: got %0d words want 18", got_d.size());
      end
      for (int j = 0; j < 18 && j < got_d.size(); j++) begin
         tests_run++;
         if ({got_d[j], got_l[j]} !== {32'h50000000 | ((j / 6) << 8) | (j % 6), (j % 6 == 5)}) begin
            tests_failed++;
            $display("FAIL stream_word%0d: d=%h last=%b want %h %b", j, got_d[j], got_l[j],
                     32'h50000000 | ((j / 6) << 8) | (j % 6), (j % 6 == 5));
         end
      end

      // Committed-but-unread packet plus a partial one, then reset
      tx[0] = 32'h33333333; tx[1] = 32'h44444444;
      send_pkt(2, 16'd8, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         rec_data_en = 1'b1; rec_data = 32'h99990000 + i; rec_byte_num = 16'd16;
      end
      do_reset();
      tests_run++;
      if ({pkt_valid, rd_valid, rd_last, overflow, rd_data, pkt_len, drop_cnt} !== 68'd0) begin
         tests_failed++;
         $display("FAIL rst_mid: pv=%b rv=%b last=%b ovf=%b d=%h len=%0d drop=%0d want all 0",
                  pkt_valid, rd_valid, rd_last, overflow, rd_data, pkt_len, drop_cnt);
      end
      repeat (5) @(negedge sys_clk);
      tests_run++;
      if ({pkt_valid, rd_valid} !== 2'b00) begin
         tests_failed++; $display("FAIL rst_no_partial: pv=%b rv=%b want 0 0", pkt_valid, rd_valid);
      end
      tx[0] = 32'h77770001; tx[1] = 32'h77770002;
      send_pkt(2, 16'd7, 1'b0);
      wait_valid(ok);
      for (int i = 0; i < 2; i++) begin
         read_word(d, l, v, len);
         tests_run++;
         if ({ok, v, d, l, len} !== {2'b11, tx[i], (i == 1), 16'd7}) begin
            tests_failed++;
            $display("FAIL rst_after_word%0d: ok=%b v=%b d=%h last=%b len=%0d want 1 1 %h %b 7",
                     i, ok, v, d, l, len, tx[i], (i == 1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_good_packet();
      test_error_rollback();
      test_overflow();
      test_desc_full();
      test_len_mismatch();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
